// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush sequencing controller for the 5-stage OTTER pipeline
//
// Purpose:
//   Produces per-stage register write enables and flush controls for three cases:
//   load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
//   Also keeps saturating stall/flush counters and a DMEM timeout watchdog.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   ID_RS1/ID_RS2         source registers of the instruction in ID
//   ID_RS1_USED/_RS2_USED the ID instruction actually reads that source
//   ID_EX_RD, ID_EX_MEMREAD  destination / is-load of the instruction in EX
//   EX_BRANCH_TAKEN       branch/jump in EX redirects the fetch stream
//   DMEM_BUSY             data memory cannot complete this cycle
//   CLR_CNT               synchronous clear of counters and MEM_ERR
//   PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE        stage register enables
//   IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH      stage bubble insertion
//   STALL_CNT, FLUSH_CNT  saturating performance counters
//   MEM_ERR, HALTED       sticky timeout flag, FSM-in-HALT indicator
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_RS1_USED,
    input  logic             ID_RS2_USED,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_MEMREAD,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             DMEM_BUSY,
    input  logic             CLR_CNT,
    output logic             PC_WE,
    output logic             IF_ID_WE,
    output logic             ID_EX_WE,
    output logic             EX_MEM_WE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             MEM_WB_FLUSH,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic             MEM_ERR,
    output logic             HALTED
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    // Halt on the busy cycle that would make the wait count reach MEM_TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic lu;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic flush_inc, stall_inc, err_set;

    always_comb begin
        lu = ID_EX_MEMREAD && (ID_EX_RD != 5'd0) &&
             ((ID_RS1_USED && (ID_EX_RD == ID_RS1)) ||
              (ID_RS2_USED && (ID_EX_RD == ID_RS2)));

        state_d      = state_q;
        wait_d       = wait_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        flush_inc    = 1'b0;
        err_set      = 1'b0;

        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (DMEM_BUSY) begin
                    // Freeze everything up to EX/MEM; MEM/WB gets a bubble
                    // so the stalled access does not retire twice.
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_we     = 1'b0;
                    ex_mem_we    = 1'b0;
                    mem_wb_flush = 1'b1;
                    if (state_q == S_RUN) begin
                        state_d = S_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                        if (wait_q >= WAIT_LAST) begin
                            state_d = S_HALT;
                            err_set = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_RUN;
                    wait_d  = '0;
                    // A taken branch kills the dependent ID instruction, so it
                    // overrides the load-use stall.
                    if (EX_BRANCH_TAKEN) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (lu) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            S_HALT: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_we  = 1'b0;
                ex_mem_we = 1'b0;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase

        stall_inc = (state_q != S_HALT) && !pc_we;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CLR_CNT) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        // A fresh timeout is never lost to a coincident clear.
        if (err_set)      mem_err_d = 1'b1;
        else if (CLR_CNT) mem_err_d = 1'b0;
        else              mem_err_d = mem_err_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Outputs are forced to the safe reset pattern for as long as RST is high,
    // independent of the clock.
    always_comb begin
        if (RST) begin
            PC_WE        = 1'b0;
            IF_ID_WE     = 1'b0;
            ID_EX_WE     = 1'b0;
            EX_MEM_WE    = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            MEM_WB_FLUSH = 1'b1;
            STALL_CNT    = '0;
            FLUSH_CNT    = '0;
            MEM_ERR      = 1'b0;
            HALTED       = 1'b0;
        end else begin
            PC_WE        = pc_we;
            IF_ID_WE     = if_id_we;
            ID_EX_WE     = id_ex_we;
            EX_MEM_WE    = ex_mem_we;
            IF_ID_FLUSH  = if_id_flush;
            ID_EX_FLUSH  = id_ex_flush;
            MEM_WB_FLUSH = mem_wb_flush;
            STALL_CNT    = stall_cnt_q;
            FLUSH_CNT    = flush_cnt_q;
            MEM_ERR      = mem_err_q;
            HALTED       = (state_q == S_HALT);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard testbench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
    logic       id_rs1_used = 0, id_rs2_used = 0, id_ex_memread = 0;
    logic       ex_branch_taken = 0, dmem_busy = 0, clr_cnt = 0;
    logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic       if_id_flush, id_ex_flush, mem_wb_flush;
    logic [3:0] stall_cnt, flush_cnt;
    logic       mem_err, halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];
    string       name_q[$];

    // {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_LU   = 7'b0011_010;
    localparam logic [6:0] C_BR   = 7'b1111_110;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_HLT  = 7'b0000_000;
    localparam logic [6:0] C_RST  = 7'b0000_111;

    hazard_stall_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .CLK(clk), .RST(rst),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_RS1_USED(id_rs1_used), .ID_RS2_USED(id_rs2_used),
        .ID_EX_RD(id_ex_rd), .ID_EX_MEMREAD(id_ex_memread),
        .EX_BRANCH_TAKEN(ex_branch_taken), .DMEM_BUSY(dmem_busy), .CLR_CNT(clr_cnt),
        .PC_WE(pc_we), .IF_ID_WE(if_id_we), .ID_EX_WE(id_ex_we), .EX_MEM_WE(ex_mem_we),
        .IF_ID_FLUSH(if_id_flush), .ID_EX_FLUSH(id_ex_flush), .MEM_WB_FLUSH(mem_wb_flush),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt),
        .MEM_ERR(mem_err), .HALTED(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [6:0] c, input int s, input int f,
                                       input logic e, input logic h);
        return {c, 4'(s), 4'(f), e, h};
    endfunction

    // Inputs change 1 time unit after the rising edge; the expectation describes
    // what the DUT shows for the rest of that cycle (counters = value before the
    // next edge). async_rst raises RST between edges after the inputs are applied.
    task automatic drive(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic busy, input logic clr,
                         input logic r, input logic async_rst, input logic [16:0] exp);
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_ex_rd = rd; id_ex_memread = mr; ex_branch_taken = br;
        dmem_busy = busy; clr_cnt = clr; rst = r;
        if (async_rst) begin
            #2;
            rst = 1'b1;
        end
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        logic [16:0] act, e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
                       mem_wb_flush, stall_cnt, flush_cnt, mem_err, halted};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: actual ctl=%b stall=%0d flush=%0d err=%b halt=%b, required ctl=%b stall=%0d flush=%0d err=%b halt=%b",
                             nm, act[16:10], act[9:6], act[5:2], act[1], act[0],
                             e[16:10], e[9:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        //      name          rs1 rs2 u1 u2 rd mr br bz cl rs as expected
        drive("reset",        0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, mk(C_RST, 0, 0, 0, 0));
        drive("idle",         0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 0, 0, 0, 0));
        drive("lu_rs1",       5,  0,  1, 0, 5, 1, 0, 0, 0, 0, 0, mk(C_LU, 0, 0, 0, 0));
        drive("after_lu",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 1, 0, 0, 0));
        drive("rs1_unused",   5,  5,  0, 0, 5, 1, 0, 0, 0, 0, 0, mk(C_NORM, 1, 0, 0, 0));
        drive("rd_zero",      0,  0,  1, 1, 0, 1, 0, 0, 0, 0, 0, mk(C_NORM, 1, 0, 0, 0));
        drive("no_memread",   5,  0,  1, 0, 5, 0, 0, 0, 0, 0, 0, mk(C_NORM, 1, 0, 0, 0));
        drive("lu_rs2",       3,  7,  1, 1, 7, 1, 0, 0, 0, 0, 0, mk(C_LU, 1, 0, 0, 0));
        drive("branch_lu",    5,  0,  1, 0, 5, 1, 1, 0, 0, 0, 0, mk(C_BR, 2, 0, 0, 0));
        drive("after_br",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 2, 1, 0, 0));
        drive("busy1",        0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 2, 1, 0, 0));
        drive("busy2_br",     0,  0,  0, 0, 0, 0, 1, 1, 0, 0, 0, mk(C_FRZ, 3, 1, 0, 0));
        drive("busy3_lu",     5,  0,  1, 0, 5, 1, 1, 1, 0, 0, 0, mk(C_FRZ, 4, 1, 0, 0));
        drive("wait_exit_br", 5,  0,  1, 0, 5, 1, 1, 0, 0, 0, 0, mk(C_BR, 5, 1, 0, 0));
        drive("run_again",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 5, 2, 0, 0));
        for (int i = 0; i < 20; i++) begin
            s = (5 + i > 15) ? 15 : 5 + i;
            drive("sat_lu",   9,  0,  1, 0, 9, 1, 0, 0, 0, 0, 0, mk(C_LU, s, 2, 0, 0));
        end
        drive("clr_with_lu",  9,  0,  1, 0, 9, 1, 0, 0, 1, 0, 0, mk(C_LU, 15, 2, 0, 0));
        drive("after_clr",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 0, 0, 0, 0));
        drive("to_busy1",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 0, 0, 0, 0));
        drive("to_busy2",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 1, 0, 0, 0));
        drive("to_busy3",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 2, 0, 0, 0));
        drive("to_busy4",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 3, 0, 0, 0));
        drive("halted",       0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_HLT, 4, 0, 1, 1));
        drive("halt_lu_br",   5,  0,  1, 0, 5, 1, 1, 0, 0, 0, 0, mk(C_HLT, 4, 0, 1, 1));
        drive("halt_clr",     0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, mk(C_HLT, 4, 0, 1, 1));
        drive("halt_cleared", 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_HLT, 0, 0, 0, 1));
        drive("halt_reset",   0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, mk(C_RST, 0, 0, 0, 0));
        drive("post_halt",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 0, 0, 0, 0));
        drive("mw_busy1",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, mk(C_FRZ, 0, 0, 0, 0));
        drive("mw_async_rst", 0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 1, mk(C_RST, 0, 0, 0, 0));
        drive("rst_held",     0,  0,  0, 0, 0, 0, 0, 1, 0, 1, 0, mk(C_RST, 0, 0, 0, 0));
        drive("post_rst",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 0, 0, 0, 0));
        drive("post_rst_lu",  4,  0,  1, 0, 4, 1, 0, 0, 0, 0, 0, mk(C_LU, 0, 0, 0, 0));
        drive("post_rst_cnt", 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, mk(C_NORM, 1, 0, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
